// File: rtl/bcd_string_streamer_pkg.sv
// Shared character codes and FSM state encoding for the BCD-to-ASCII string streamer.
package bcd_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_BAD   = 8'h41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_string_streamer_if.sv
// Request/character-stream bundle of the BCD string streamer.
// The sign input exists only when BCD_STRING_STREAMER_SIGN_EN is defined.
interface bcd_string_streamer_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_STRING_STREAMER_SIGN_EN
  logic                  sign;
`endif
  logic                  busy;
  logic                  char_valid;
  logic [7:0]            char_data;
  logic                  char_ready;
  logic                  done;

  modport master (
    output start,
    output bcd,
`ifdef BCD_STRING_STREAMER_SIGN_EN
    output sign,
`endif
    input  busy,
    input  char_valid,
    input  char_data,
    output char_ready,
    input  done
  );

  modport slave (
    input  start,
    input  bcd,
`ifdef BCD_STRING_STREAMER_SIGN_EN
    input  sign,
`endif
    output busy,
    output char_valid,
    output char_data,
    input  char_ready,
    output done
  );
endinterface

// File: rtl/bcd_string_streamer_digit.sv
// Combinational BCD nibble to ASCII digit map; non-decimal nibbles become 'A'.
module bcd_digit_to_ascii
  import bcd_ascii_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble <= 4'd9) begin
      ascii = ASCII_ZERO + {4'd0, nibble};
    end else begin
      ascii = ASCII_BAD;
    end
  end

endmodule

// File: rtl/bcd_string_streamer.sv
// Streams a packed BCD value MSD-first as an ASCII field with optional '.', blanking
// and (when BCD_STRING_STREAMER_SIGN_EN is defined) a leading sign character.
module bcd_string_streamer
  import bcd_ascii_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int FRAC_DIGITS = 3,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_string_streamer_if.slave  bus
);

`ifdef BCD_STRING_STREAMER_SIGN_EN
  localparam int SIGN_CHARS = 1;
`else
  localparam int SIGN_CHARS = 0;
`endif
  localparam int DOT_CHARS  = (FRAC_DIGITS > 0) ? 1 : 0;
  localparam int CHAR_N     = DIGITS + DOT_CHARS + SIGN_CHARS;
  localparam int INT_DIGITS = DIGITS - FRAC_DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(CHAR_N - 1);

  state_t              state, state_n;
  logic [3:0]          idx, idx_n;
  logic [4*DIGITS-1:0] bcd_q;
  logic                sign_q;
  logic                emit_q, done_q;
  logic [7:0]          data_q, data_n;

  logic [4*DIGITS-1:0] sel_bcd;
  logic                sel_sign;
  int                  pos, digit;
  logic                is_sign, is_dot, lead_zero, blank;
  logic [3:0]          nibble;
  logic [7:0]          digit_ascii, char_n;
  logic                handshake;

  assign handshake = (state == EMIT) && emit_q && bus.char_ready;

  // Character for the next position: char 0 of the incoming value while idle,
  // otherwise the one after the current index of the latched value.
  always_comb begin
    sel_bcd  = (state == IDLE) ? bus.bcd : bcd_q;
`ifdef BCD_STRING_STREAMER_SIGN_EN
    sel_sign = (state == IDLE) ? bus.sign : sign_q;
`else
    sel_sign = sign_q;
`endif
    pos      = ((state == IDLE) ? 0 : int'(idx) + 1) - SIGN_CHARS;
    is_sign  = (pos < 0);
    is_dot   = (DOT_CHARS != 0) && (pos == INT_DIGITS);
    digit    = ((DOT_CHARS != 0) && (pos > INT_DIGITS)) ? pos - 1 : pos;
    if (digit < 0)          digit = 0;
    if (digit > DIGITS - 1) digit = DIGITS - 1;
    nibble    = 4'(sel_bcd >> (4 * (DIGITS - 1 - digit)));
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i <= digit) && (4'(sel_bcd >> (4 * (DIGITS - 1 - i))) != 4'd0)) begin
        lead_zero = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && lead_zero && (digit < INT_DIGITS - 1);
  end

  bcd_digit_to_ascii u_digit (
    .nibble (nibble),
    .ascii  (digit_ascii)
  );

  always_comb begin
    if (is_sign)     char_n = sel_sign ? ASCII_MINUS : ASCII_SPACE;
    else if (is_dot) char_n = ASCII_DOT;
    else if (blank)  char_n = ASCII_SPACE;
    else             char_n = digit_ascii;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 4'd0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      emit_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      data_q <= data_n;
      emit_q <= (state_n == EMIT);
      done_q <= (state_n == DONE);
      if ((state == IDLE) && bus.start) begin
        bcd_q  <= bus.bcd;
        sign_q <= sel_sign;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = EMIT;
      EMIT:    if (handshake && (idx == LAST_IDX)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Character data only moves on a start or an accepted handshake, so it is stable under backpressure.
  always_comb begin
    idx_n  = idx;
    data_n = data_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_n  = 4'd0;
          data_n = char_n;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (idx == LAST_IDX) begin
            idx_n = 4'd0;
          end else begin
            idx_n  = idx + 4'd1;
            data_n = char_n;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy       = emit_q;
  assign bus.char_valid = emit_q;
  assign bus.char_data  = data_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bcd_string_streamer.sv
// Scoreboard bench for bcd_string_streamer: two instances (FRAC_DIGITS=3 and 1).
module tb_bcd_string_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_string_streamer_if #(.DIGITS(4)) bus_a ();
  bcd_string_streamer_if #(.DIGITS(4)) bus_b ();

  bcd_string_streamer #(.DIGITS(4), .FRAC_DIGITS(3), .BLANK_LZ(1)) u_dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  bcd_string_streamer #(.DIGITS(4), .FRAC_DIGITS(1), .BLANK_LZ(1)) u_dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  logic        start_v [2];
  logic [15:0] bcd_v   [2];
  logic        ready_v [2];
  logic        sign_v  [2];
  logic        busy_w  [2];
  logic        valid_w [2];
  logic [7:0]  data_w  [2];
  logic        done_w  [2];

  assign bus_a.start = start_v[0];
  assign bus_b.start = start_v[1];
  assign bus_a.bcd   = bcd_v[0];
  assign bus_b.bcd   = bcd_v[1];
  assign bus_a.char_ready = ready_v[0];
  assign bus_b.char_ready = ready_v[1];
`ifdef BCD_STRING_STREAMER_SIGN_EN
  assign bus_a.sign = sign_v[0];
  assign bus_b.sign = sign_v[1];
`endif
  assign busy_w[0]  = bus_a.busy;
  assign busy_w[1]  = bus_b.busy;
  assign valid_w[0] = bus_a.char_valid;
  assign valid_w[1] = bus_b.char_valid;
  assign data_w[0]  = bus_a.char_data;
  assign data_w[1]  = bus_b.char_data;
  assign done_w[0]  = bus_a.done;
  assign done_w[1]  = bus_b.done;

  logic [7:0] exp_q [2][$];
  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference string: digits first, then blanking of leading integer zeros, then '.'.
  function automatic int pushString(input int k, input logic [15:0] b, input bit s);
    int         frac     = (k == 1) ? 1 : 3;
    int         last_int = 3 - frac;
    bit         blanking = 1'b1;
    int         len      = 0;
    logic [3:0] nib;
    logic [7:0] c;
`ifdef BCD_STRING_STREAMER_SIGN_EN
    exp_q[k].push_back(s ? 8'h2D : 8'h20);
    len++;
`endif
    for (int d = 0; d < 4; d++) begin
      nib = 4'(b >> (12 - 4 * d));
      c   = (nib > 4'd9) ? 8'h41 : (8'h30 + {4'd0, nib});
      if (blanking && (nib == 4'd0) && (d < last_int)) c = 8'h20;
      else blanking = 1'b0;
      exp_q[k].push_back(c);
      len++;
      if ((frac > 0) && (d == last_int)) begin
        exp_q[k].push_back(8'h2E);
        len++;
      end
    end
    return len;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && valid_w[k] && ready_v[k]) begin
        if (exp_q[k].size() == 0) checkOutput($sformatf("char%0d_unexpected", k), {24'd0, data_w[k]}, 32'h100);
        else checkOutput($sformatf("char%0d", k), {24'd0, data_w[k]}, {24'd0, exp_q[k].pop_front()});
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [15:0] b, input bit s,
                               input bit bp, input bit meddle);
    int len;
    int busy_cnt = 0;
    int cyc;
    len = pushString(k, b, s);
    @(posedge clk); #1;
    start_v[k] = 1'b1; bcd_v[k] = b; sign_v[k] = s; ready_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (exp_q[k].size() == 0) break;
      if (busy_w[k]) busy_cnt++;
      ready_v[k] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (meddle && cyc == 2) begin start_v[k] = 1'b1; bcd_v[k] = 16'hFFFF; sign_v[k] = ~s; end
      if (meddle && cyc == 3) start_v[k] = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("stream_left", exp_q[k].size(), 0);
    exp_q[k].delete();
    checkOutput("done_pulse", {31'd0, done_w[k]}, 1);
    checkOutput("busy_in_done", {31'd0, busy_w[k]}, 0);
    checkOutput("valid_in_done", {31'd0, valid_w[k]}, 0);
    if (!bp) checkOutput("busy_cycles", busy_cnt, len);
    if (meddle) start_v[k] = 1'b1;
    ready_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    checkOutput("done_cleared", {31'd0, done_w[k]}, 0);
    if (meddle) begin
      repeat (3) begin
        @(posedge clk); #1;
        checkOutput("no_restart", {31'd0, valid_w[k] | busy_w[k]}, 0);
      end
    end
  endtask

  task automatic midStreamReset();
    void'(pushString(0, 16'h4321, 1'b0));
    @(posedge clk); #1;
    start_v[0] = 1'b1; bcd_v[0] = 16'h4321; sign_v[0] = 1'b0; ready_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_valid", {31'd0, valid_w[0]}, 0);
    checkOutput("rst_busy", {31'd0, busy_w[0]}, 0);
    checkOutput("rst_data", {24'd0, data_w[0]}, 0);
    checkOutput("rst_done", {31'd0, done_w[0]}, 0);
    exp_q[0].delete();
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("no_done_after_rst", {31'd0, done_w[0] | valid_w[0]}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0; bcd_v[k] = 16'h0; ready_v[k] = 1'b1; sign_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_valid", {31'd0, valid_w[k]}, 0);
      checkOutput("reset_busy", {31'd0, busy_w[k]}, 0);
      checkOutput("reset_data", {24'd0, data_w[k]}, 0);
      checkOutput("reset_done", {31'd0, done_w[k]}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic string, full throughput");
    applyStimulus(0, 16'h1234, 1'b0, 1'b0, 1'b0);
    $display("[TB] leading-zero blanking with one fraction digit");
    applyStimulus(1, 16'h0050, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 16'h0050, 1'b0, 1'b0, 1'b0);
    $display("[TB] backpressure");
    applyStimulus(0, 16'h9876, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 16'h0109, 1'b0, 1'b1, 1'b0);
    $display("[TB] invalid nibble and ignored restarts");
    applyStimulus(0, 16'h1A23, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 16'h0B00, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset mid-stream");
    midStreamReset();
    applyStimulus(0, 16'h5678, 1'b0, 1'b0, 1'b0);
    $display("[TB] sign character");
    applyStimulus(0, 16'h0250, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 16'h0250, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
